// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams LEN words from a fixed-latency block RAM.
// Credit-gated issue plus a small skid FIFO gives full backpressure.
module bram_stream_reader #(
  parameter int D_WIDTH = 72,
  parameter int A_WIDTH = 10,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   len,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] ram_addr,
  input  logic [D_WIDTH-1:0] ram_dout,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready
);

  localparam int FIFO_DEPTH = LATENCY + 3;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [A_WIDTH-1:0] r_base;
  logic [A_WIDTH-1:0] r_addr;
  logic [A_WIDTH:0]   r_len;
  logic [A_WIDTH:0]   r_icnt;
  logic [A_WIDTH:0]   r_ocnt;
  logic               r_done;
  logic [LATENCY:0]   r_vpipe;
  logic [CW-1:0]      r_infl;
  logic [CW-1:0]      r_fcnt;
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic               w_accept;
  logic               w_start;
  logic               w_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_last;
  logic [A_WIDTH:0]   w_icnt_nxt;
  logic [A_WIDTH:0]   w_lastidx;
  logic [PW-1:0]      w_wp_nxt;
  logic [PW-1:0]      w_rp_nxt;

  // the done cycle still counts as busy, so start is ignored there
  assign w_accept = (r_state == S_IDLE) && !r_done && start;
  assign w_start  = w_accept && (len != '0);

  assign w_credit = (r_fcnt + r_infl) < CW'(FIFO_DEPTH);
  assign w_issue  = w_start ||
                    ((r_state == S_READ) && w_credit);
  assign w_push   = r_vpipe[LATENCY];
  assign w_pop    = m_valid && m_ready;
  assign w_last   = w_pop && m_last;

  assign w_icnt_nxt = r_icnt + (A_WIDTH+1)'(1);
  assign w_lastidx  = r_len - (A_WIDTH+1)'(1);

  assign w_wp_nxt = (r_wp == PW'(FIFO_DEPTH-1)) ?
                    '0 : r_wp + PW'(1);
  assign w_rp_nxt = (r_rp == PW'(FIFO_DEPTH-1)) ?
                    '0 : r_rp + PW'(1);

  assign m_valid  = (r_fcnt != '0);
  assign m_data   = r_mem[r_rp];
  assign m_last   = m_valid && (r_ocnt == w_lastidx);
  assign ram_addr = r_addr;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE) || r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_icnt  <= '0;
      r_ocnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) r_ocnt <= r_ocnt + (A_WIDTH+1)'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && (len == '0)) begin
            r_done <= 1'b1;
          end else if (w_start) begin
            r_base <= base_addr;
            r_len  <= len;
            r_addr <= base_addr;
            r_icnt <= (A_WIDTH+1)'(1);
            r_ocnt <= '0;
            r_state <= (len == (A_WIDTH+1)'(1)) ?
                       S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_addr <= r_base + r_icnt[A_WIDTH-1:0];
            r_icnt <= w_icnt_nxt;
            if (w_icnt_nxt == r_len) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // tracker tail lines up with ram_dout of the matching issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
      r_infl  <= '0;
      r_fcnt  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      r_vpipe <= {r_vpipe[LATENCY-1:0], w_issue};
      r_infl  <= r_infl + CW'(w_issue) - CW'(w_push);
      r_fcnt  <= r_fcnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= w_wp_nxt;
      if (w_pop)  r_rp <= w_rp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= ram_dout;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: RAM model, scoreboard queue and monitor.
// Directed commands with hand-derived cycle numbers.
module tb_bram_stream_reader;
  localparam int DW = 72;
  localparam int AW = 4;
  localparam int LAT = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .D_WIDTH(DW), .A_WIDTH(AW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .len(len),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready)
  );

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd1;

  always @(posedge clk) begin
    rd1      <= ram[ram_addr];
    ram_dout <= rd1;
  end

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  bit            rec_addr = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   mon_e;

  function automatic logic [DW-1:0] memv(input int a);
    return {8'hA5, 32'h0, 32'(a)};
  endfunction

  function automatic logic rdy(input int mode, input int k);
    return (mode == 0) || (((k - 1) % 3) == 0);
  endfunction

  task automatic check(input string name,
                       input logic [79:0] act,
                       input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 80'(m_valid), 80'(1));
        check("hold_data", 80'(m_data), 80'(prev_data));
        check("hold_last", 80'(m_last), 80'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 80'(1), 80'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("data", 80'(m_data), 80'(mon_e[DW-1:0]));
          check("last", 80'(m_last), 80'(mon_e[DW]));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_cnt++;
        check("busy_at_done", 80'(busy), 80'(1));
      end
      check("fifo_bound",
            80'(dut.r_fcnt <= (LAT + 3)), 80'(1));
      if (rec_addr && (addr_q.size() == 0 ||
                       addr_q[$] != ram_addr))
        addr_q.push_back(ram_addr);
    end
  end

  task automatic run_cmd(input int b, input int l,
                         input int mode, input int spur,
                         output int first_v,
                         output int done_k,
                         output int nvalid);
    int k;
    int d0;
    bit busy_ok;
    for (int i = 0; i < l; i++)
      exp_q.push_back({(i == l - 1), memv((b + i) % DEPTH)});
    d0 = done_cnt;
    first_v = -1;
    done_k = -1;
    nvalid = 0;
    busy_ok = 1'b1;
    addr_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    m_ready = rdy(mode, 0);
    k = 1;
    while (done_k < 0 && k < 300) begin
      @(posedge clk); #1;
      start = (k == spur);
      if (k == spur) begin
        base_addr = '0;
        len = (AW+1)'(1);
      end
      m_ready = rdy(mode, k);
      rec_addr = 1'b1;
      @(negedge clk);
      if (m_valid) begin
        nvalid++;
        if (first_v < 0) first_v = k;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) done_k = k;
      k++;
    end
    rec_addr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    m_ready = 1'b1;
    check("done_seen", 80'(done_k >= 0), 80'(1));
    check("busy_held", 80'(busy_ok), 80'(1));
    @(negedge clk);
    check("busy_after", 80'(busy), 80'(0));
    check("done_once", 80'(done_cnt - d0), 80'(1));
    check("queue_empty", 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, dk, nv, d0;
    bit quiet;
    for (int i = 0; i < DEPTH; i++) ram[i] = memv(i);
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_done", 80'(done), 80'(0));
    check("rst_valid", 80'(m_valid), 80'(0));
    check("rst_last", 80'(m_last), 80'(0));
    check("rst_addr", 80'(ram_addr), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(5, 4, 0, -1, fv, dk, nv);
    check("basic_first_valid", 80'(fv), 80'(4));
    check("basic_done_cycle", 80'(dk), 80'(8));
    check("basic_nvalid", 80'(nv), 80'(4));

    run_cmd(5, 4, 1, -1, fv, dk, nv);
    check("bp_first_valid", 80'(fv), 80'(4));
    check("bp_done_cycle", 80'(dk), 80'(14));

    run_cmd(14, 4, 0, -1, fv, dk, nv);
    check("wrap_done_cycle", 80'(dk), 80'(8));
    check("wrap_naddr", 80'(addr_q.size()), 80'(4));
    if (addr_q.size() == 4)
      check("wrap_addrs",
            80'({addr_q[0], addr_q[1], addr_q[2], addr_q[3]}),
            80'({4'd14, 4'd15, 4'd0, 4'd1}));

    run_cmd(3, 0, 0, -1, fv, dk, nv);
    check("len0_done_cycle", 80'(dk), 80'(1));
    check("len0_no_valid", 80'(nv), 80'(0));

    run_cmd(9, 16, 0, -1, fv, dk, nv);
    check("sweep_first_valid", 80'(fv), 80'(4));
    check("sweep_done_cycle", 80'(dk), 80'(20));
    check("sweep_nvalid", 80'(nv), 80'(16));

    exp_q.push_back({1'b0, memv(0)});
    exp_q.push_back({1'b0, memv(1)});
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = '0;
    len = (AW+1)'(8);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 6) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 80'(m_valid), 80'(0));
    check("abort_busy", 80'(busy), 80'(0));
    check("abort_xfers", 80'(exp_q.size()), 80'(0));
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_valid || busy) quiet = 1'b0;
    end
    check("abort_quiet", 80'(quiet), 80'(1));
    check("abort_no_done", 80'(done_cnt - d0), 80'(0));

    run_cmd(0, 2, 0, -1, fv, dk, nv);
    check("post_rst_first_valid", 80'(fv), 80'(4));
    check("post_rst_done_cycle", 80'(dk), 80'(6));

    run_cmd(5, 4, 0, 2, fv, dk, nv);
    check("ign_mid_done_cycle", 80'(dk), 80'(8));
    run_cmd(5, 4, 0, 8, fv, dk, nv);
    check("ign_done_done_cycle", 80'(dk), 80'(8));
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("ign_no_extra_done", 80'(done_cnt - d0), 80'(0));
    check("ign_queue_empty", 80'(exp_q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
